// File: rtl/debounce_bank.sv
// Per-channel button conditioner: 2-FF synchroniser, stable-time filter,
// registered press/release pulses and a long-press / auto-repeat hold pulse.
module debounce_bank #(
  parameter int CHANNELS    = 4,
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int HOLD_MS     = 1000,
  parameter int REPEAT_MS   = 200,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] btn_raw,
  output logic [CHANNELS-1:0] btn_level,
  output logic [CHANNELS-1:0] btn_press,
  output logic [CHANNELS-1:0] btn_release,
  output logic [CHANNELS-1:0] btn_hold
);

  localparam int CYC_PER_MS    = CLK_FREQ_HZ / 1000;
  localparam int STABLE_CYCLES = DEBOUNCE_MS * CYC_PER_MS;
  localparam int HOLD_CYCLES   = HOLD_MS * CYC_PER_MS;
  localparam int REPEAT_CYCLES = REPEAT_MS * CYC_PER_MS;
  localparam int HMAX          = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CW            = $clog2(STABLE_CYCLES + 1);
  localparam int HW            = $clog2(HMAX + 1);

  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] REPEAT_LAST = HW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
  localparam logic [CHANNELS-1:0] POL   = (ACTIVE_LOW != 0) ? '1 : '0;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_HOLD, ST_REPEAT} hold_state_t;

  logic [CHANNELS-1:0] w_norm;
  assign w_norm = btn_raw ^ POL;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic          r_s1_p0, r_s2_p1;
    logic          r_level, r_press, r_release, r_hold;
    logic [CW-1:0] r_cnt;
    logic [HW-1:0] r_hcnt;
    hold_state_t   r_state;
    logic          w_flip, w_rise, w_fall;

    // Level changes on the same edge that the pulses and hold FSM react to.
    assign w_flip = (r_s2_p1 != r_level) && (r_cnt == STABLE_LAST);
    assign w_rise = w_flip && r_s2_p1;
    assign w_fall = w_flip && !r_s2_p1;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_s1_p0   <= 1'b0;
        r_s2_p1   <= 1'b0;
        r_level   <= 1'b0;
        r_cnt     <= '0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_s1_p0   <= w_norm[g];
        r_s2_p1   <= r_s1_p0;
        r_press   <= w_rise;
        r_release <= w_fall;
        if (r_s2_p1 == r_level) begin
          r_cnt <= '0;
        end else if (w_flip) begin
          r_level <= r_s2_p1;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_state <= ST_IDLE;
        r_hcnt  <= '0;
        r_hold  <= 1'b0;
      end else begin
        r_hold <= 1'b0;
        if (w_fall) begin
          // Release wins over any pulse due this cycle.
          r_state <= ST_IDLE;
          r_hcnt  <= '0;
        end else begin
          case (r_state)
            ST_IDLE: begin
              if (w_rise) begin
                r_state <= ST_WAIT_HOLD;
                r_hcnt  <= '0;
              end
            end
            ST_WAIT_HOLD: begin
              if (r_hcnt == HOLD_LAST) begin
                r_hold  <= 1'b1;
                r_hcnt  <= '0;
                r_state <= ST_REPEAT;
              end else begin
                r_hcnt <= r_hcnt + 1'b1;
              end
            end
            ST_REPEAT: begin
              if (REPEAT_CYCLES > 0) begin
                if (r_hcnt == REPEAT_LAST) begin
                  r_hold <= 1'b1;
                  r_hcnt <= '0;
                end else begin
                  r_hcnt <= r_hcnt + 1'b1;
                end
              end
            end
            default: begin
              r_state <= ST_IDLE;
              r_hcnt  <= '0;
            end
          endcase
        end
      end
    end

    assign btn_level[g]   = r_level;
    assign btn_press[g]   = r_press;
    assign btn_release[g] = r_release;
    assign btn_hold[g]    = r_hold;
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: directed scenarios with literal timing checks,
// then randomized pin activity compared every cycle against a window/age model.
module tb_debounce_bank;

  localparam int NCH  = 4;
  localparam int S    = 4;
  localparam int HOLD = 10;
  localparam int REP  = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic [NCH-1:0] btn_raw;
  logic [NCH-1:0] lvl_a, prs_a, rel_a, hld_a;
  logic [NCH-1:0] lvl_b, prs_b, rel_b, hld_b;

  always #5 clk = ~clk;

  debounce_bank #(.CHANNELS(NCH), .CLK_FREQ_HZ(1000), .DEBOUNCE_MS(4), .HOLD_MS(10),
                  .REPEAT_MS(3), .ACTIVE_LOW(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
    .btn_level(lvl_a), .btn_press(prs_a), .btn_release(rel_a), .btn_hold(hld_a));

  debounce_bank #(.CHANNELS(NCH), .CLK_FREQ_HZ(1000), .DEBOUNCE_MS(4), .HOLD_MS(10),
                  .REPEAT_MS(0), .ACTIVE_LOW(1)) u_dut_r0 (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
    .btn_level(lvl_b), .btn_press(prs_b), .btn_release(rel_b), .btn_hold(hld_b));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit cmp_en = 1'b0;

  // Model: h holds pressed-pin history (bit0 = newest edge); age = edges since press.
  logic [31:0] h [NCH];
  int age [NCH];
  logic [NCH-1:0] e_lvl = '0, e_prs = '0, e_rel = '0, e_hla = '0, e_hlb = '0;
  int pc_a [NCH], rc_a [NCH], hc_a [NCH], hc_b [NCH];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      cmp_en = 1'b1;
      e_lvl = '0; e_prs = '0; e_rel = '0; e_hla = '0; e_hlb = '0;
      for (int c = 0; c < NCH; c++) begin
        h[c] = '0;
        age[c] = -1;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        logic [31:0] win;
        bit flip;
        h[c] = {h[c][30:0], ~btn_raw[c]};
        // Filter sees the pin two edges late; flip after S consecutive opposite samples.
        win = (h[c] >> 2) & ((32'd1 << S) - 32'd1);
        flip = e_lvl[c] ? (win == 32'd0) : (win == ((32'd1 << S) - 32'd1));
        e_prs[c] = 1'b0; e_rel[c] = 1'b0; e_hla[c] = 1'b0; e_hlb[c] = 1'b0;
        if (flip && !e_lvl[c]) begin
          e_lvl[c] = 1'b1; e_prs[c] = 1'b1; age[c] = 0;
        end else if (flip) begin
          e_lvl[c] = 1'b0; e_rel[c] = 1'b1; age[c] = -1;
        end else if (e_lvl[c]) begin
          age[c]++;
          e_hla[c] = (age[c] == HOLD) || (age[c] > HOLD && (age[c] - HOLD) % REP == 0);
          e_hlb[c] = (age[c] == HOLD);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("level_a",   int'(lvl_a), int'(e_lvl));
      chk("press_a",   int'(prs_a), int'(e_prs));
      chk("release_a", int'(rel_a), int'(e_rel));
      chk("hold_a",    int'(hld_a), int'(e_hla));
      chk("level_b",   int'(lvl_b), int'(e_lvl));
      chk("press_b",   int'(prs_b), int'(e_prs));
      chk("release_b", int'(rel_b), int'(e_rel));
      chk("hold_b",    int'(hld_b), int'(e_hlb));
      for (int c = 0; c < NCH; c++) begin
        if (prs_a[c]) pc_a[c]++;
        if (rel_a[c]) rc_a[c]++;
        if (hld_a[c]) hc_a[c]++;
        if (hld_b[c]) hc_b[c]++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_pulse(input int ch, input int kind, input int maxc, output int at);
    at = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if ((kind == 0 && prs_a[ch]) || (kind == 1 && rel_a[ch]) || (kind == 2 && hld_a[ch])) begin
        at = cyc;
        break;
      end
    end
  endtask

  int e0, p, at, at2, base, hb, hbb;
  int rl [NCH];

  initial begin
    for (int c = 0; c < NCH; c++) begin
      pc_a[c] = 0; rc_a[c] = 0; hc_a[c] = 0; hc_b[c] = 0; rl[c] = 0;
    end
    btn_raw = 4'hF;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    tick(20);
    chk("reset_level", int'(lvl_a), 0);
    chk("reset_pulses", pc_a[0] + pc_a[1] + pc_a[2] + pc_a[3] + rc_a[0] + rc_a[1] + rc_a[2]
        + rc_a[3] + hc_a[0] + hc_a[1] + hc_a[2] + hc_a[3], 0);

    // Clean press / release on ch0
    btn_raw[0] = 1'b0; e0 = cyc + 1;
    wait_pulse(0, 0, 30, at);
    chk("ch0_press_lat", at, e0 + 5);
    tick(20);
    btn_raw[0] = 1'b1; e0 = cyc + 1;
    wait_pulse(0, 1, 30, at);
    chk("ch0_release_lat", at, e0 + 5);
    chk("ch0_level_after_release", int'(lvl_a[0]), 0);
    tick(5);

    // Bounce on ch1: 2-cycle runs never qualify
    base = pc_a[1];
    for (int i = 0; i < 15; i++) begin
      btn_raw[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
      if (i == 14) e0 = cyc + 1;
      tick(2);
    end
    chk("bounce_no_press", pc_a[1] - base, 0);
    chk("bounce_level", int'(lvl_a[1]), 0);
    wait_pulse(1, 0, 30, at);
    chk("bounce_press_lat", at, e0 + 5);
    tick(3);
    chk("bounce_press_count", pc_a[1] - base, 1);
    btn_raw[1] = 1'b1;
    tick(15);

    // Long press ch2: level high 40 cycles
    hb = hc_a[2]; hbb = hc_b[2];
    btn_raw[2] = 1'b0;
    wait_pulse(2, 0, 30, p);
    wait_pulse(2, 2, 30, at);
    chk("ch2_first_hold", at, p + 10);
    tick(24);
    btn_raw[2] = 1'b1;
    wait_pulse(2, 1, 40, at);
    chk("ch2_release", at, p + 40);
    tick(10);
    chk("ch2_hold_count", hc_a[2] - hb, 10);
    chk("ch2_hold_count_r0", hc_b[2] - hbb, 1);

    // Short press ch3: released before hold threshold
    hb = hc_a[3]; hbb = hc_b[3];
    btn_raw[3] = 1'b0;
    wait_pulse(3, 0, 30, p);
    tick(3);
    btn_raw[3] = 1'b1;
    wait_pulse(3, 1, 30, at);
    chk("ch3_short_release", at, p + 9);
    tick(15);
    chk("ch3_short_no_hold", hc_a[3] - hb, 0);
    chk("ch3_short_no_hold_r0", hc_b[3] - hbb, 0);

    // ch3 40-cycle hold: repeat disabled gives exactly one pulse
    hb = hc_a[3]; hbb = hc_b[3];
    btn_raw[3] = 1'b0;
    wait_pulse(3, 0, 30, p);
    tick(34);
    btn_raw[3] = 1'b1;
    wait_pulse(3, 1, 30, at);
    tick(10);
    chk("ch3_r0_one_hold", hc_b[3] - hbb, 1);
    chk("ch3_repeat_holds", hc_a[3] - hb, 10);

    // Mid-operation reset on ch0
    btn_raw[0] = 1'b0;
    wait_pulse(0, 0, 30, p);
    tick(4);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_level", int'(lvl_a), 0);
    chk("rst_mid_pulses", int'({prs_a, rel_a, hld_a}), 0);
    wait_pulse(0, 0, 30, at);
    chk("rst_mid_repress", at, p + 11);
    wait_pulse(0, 2, 30, at2);
    chk("rst_mid_hold", at2, at + 10);
    tick(2);
    btn_raw[0] = 1'b1;
    tick(12);

    // Randomized runs: mix of glitches and long holds, occasional reset
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < NCH; c++) begin
        if (rl[c] == 0) begin
          btn_raw[c] = 1'($urandom_range(0, 1));
          rl[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 45)) : int'($urandom_range(1, 6));
        end
        rl[c]--;
      end
      rst_n = ($urandom_range(0, 399) != 0);
      tick(1);
    end
    rst_n = 1'b1;
    btn_raw = 4'hF;
    tick(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
